cond_flag_unit: RTL and testbench
=================================

COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, flag-save stack entries (2..16).
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flag_we  input  1  latch ALU flags this cycle.
REQ-005 SHALL have ports CO, OVF, Z, N  input  1 each  ALU flag outputs.
REQ-006 SHALL have port cond_valid  input  1  condition-evaluation request.
REQ-007 SHALL have port cond  input  4  condition code.
REQ-008 SHALL have port cond_ready  output  1  request accepted when high with cond_valid.
REQ-009 SHALL have port result_valid  output  1  cond_result is valid.
REQ-010 SHALL have port result_ready  input  1  consumer takes result.
REQ-011 SHALL have port cond_result  output  1  evaluated condition.
REQ-012 SHALL have ports push, pop  input  1 each  save/restore flags.
REQ-013 SHALL have port flags  output  4  registered {N,Z,C,V}.
REQ-014 SHALL have ports stack_full, stack_empty, stack_err  output  1 each  stack status; err sticky.

Function
REQ-015 SHALL load flags <= {N,Z,CO,OVF} on a rising edge with flag_we=1.
REQ-016 SHALL evaluate cond: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-017 SHALL drive cond_ready = !result_valid | result_ready (one-entry output buffer).
REQ-018 SHALL, on handshake, register cond_result and set result_valid next cycle (latency 1).
REQ-019 SHALL hold cond_result and result_valid stable while result_valid=1 and result_ready=0.
REQ-020 SHALL clear result_valid after result_valid&result_ready unless a new request is accepted that same cycle.
REQ-021 SHALL, on push alone with stack not full, store current registered flags and increment count.
REQ-022 SHALL, on pop alone with stack not empty, restore flags from top entry and decrement count.
REQ-023 SHALL give flag_we priority over pop restore in the same cycle; the stack still pops.
REQ-024 SHALL ignore push when full, pop when empty, and push&pop together, and set stack_err in each case.
REQ-025 SHALL drive stack_full = (count==DEPTH), stack_empty = (count==0).
REQ-026 SHALL evaluate using registered flags when flag_we=0 in the request cycle.

Reset
REQ-027 SHALL on rst_n=0 asynchronously clear flags=0, result_valid=0, cond_result=0, count=0, stack_err=0.
REQ-028 SHALL drop an in-flight result on reset; cond_ready=1 and stack_empty=1 during and after reset.
REQ-029 SHALL leave stack contents undefined after reset; unreadable because count=0.

Configuration
REQ-030 SHALL, with FLAG_FWD_EN defined, evaluate a request accepted in the same cycle as flag_we against the incoming {N,Z,CO,OVF}.
REQ-031 SHALL, without FLAG_FWD_EN, evaluate that request against pre-update registered flags.

Structure
REQ-032 SHALL place condition-code constants (EQ..NV), flag bit indices and the 4-bit flags typedef in shared package cond_pkg.
REQ-033 SHALL implement the LIFO in sub-module flag_stack (DEPTH parameter, push/pop/full/empty/err).

Verification
REQ-034 SHALL cover: reset, flag_we with N=0,Z=1,CO=0,OVF=0, cond=0 -> next cycle result_valid=1, cond_result=1, flags=4'b0100.
REQ-035 SHALL cover: flags N=1,V=0, cond=A (GE) -> 0; cond=B (LT) -> 1; cond=F -> 0; cond=E -> 1.
REQ-036 SHALL cover: result_ready=0 for 3 cycles -> cond_ready=0, result held; then result_ready=1 with new request -> back-to-back valid.
REQ-037 SHALL cover: push DEPTH times -> stack_full=1; 5th push -> stack_err=1, count unchanged; pop -> flags restored to last pushed value.
REQ-038 SHALL cover: flag_we Z=1 with cond=0 in same cycle -> result 1 with FLAG_FWD_EN, prior Z without.
REQ-039 SHALL cover: rst_n low while result_valid=1 and count=2 -> result_valid=0, stack_empty=1 immediately.

Source files
------------

// File: rtl/cond_pkg.sv
// cond_pkg -- shared definitions for the condition/flag unit.
// Contents:
//   flags_t            4-bit flag vector laid out as {N,Z,C,V}
//   FLAG_N..FLAG_V     bit positions inside flags_t
//   CC_EQ..CC_NV       4-bit condition codes
//   eval_cond()        evaluates a condition code against a flag vector
package cond_pkg;

  typedef logic [3:0] flags_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  function automatic logic eval_cond(input flags_t f, input logic [3:0] cc);
    logic n;
    logic z;
    logic c;
    logic v;
    logic r;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cc)
      CC_EQ:   r = z;
      CC_NE:   r = ~z;
      CC_CS:   r = c;
      CC_CC:   r = ~c;
      CC_MI:   r = n;
      CC_PL:   r = ~n;
      CC_VS:   r = v;
      CC_VC:   r = ~v;
      CC_HI:   r = c & ~z;
      CC_LS:   r = ~c | z;
      CC_GE:   r = (n == v);
      CC_LT:   r = (n != v);
      CC_GT:   r = ~z & (n == v);
      CC_LE:   r = z | (n != v);
      CC_AL:   r = 1'b1;
      CC_NV:   r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// flag_stack -- LIFO of saved flag vectors.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, pop      save din / remove top entry (both at once is an error)
//   din            flags to save
//   top            most recently saved entry (0 when empty)
//   full, empty    occupancy status
//   err            sticky: push while full, pop while empty, or push&pop
//   pop_ok         a legal pop is being performed this cycle
// Entry storage is not reset; an entry is only readable once pushed.
module flag_stack
  import cond_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  flags_t din,
  output flags_t top,
  output logic   full,
  output logic   empty,
  output logic   err,
  output logic   pop_ok
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  flags_t          mem_q [DEPTH];
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            err_q;
  logic            err_d;
  logic            push_ok;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == {CW{1'b0}});
  assign err    = err_q;
  assign wr_idx = AW'(count_q);
  assign rd_idx = AW'(count_q - CW'(1));

  // Legal-operation decode, next count and sticky error.
  always_comb begin
    push_ok = push & ~pop & ~full;
    pop_ok  = pop & ~push & ~empty;
    err_d   = err_q | (push & pop) | (push & ~pop & full) | (pop & ~push & empty);
    if (push_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Top-of-stack read; masked while empty so no stale entry leaks out.
  always_comb begin
    if (empty) begin
      top = 4'b0000;
    end else begin
      top = mem_q[rd_idx];
    end
  end

  // Occupancy and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry storage, written on a legal push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit -- ALU flag register, condition evaluator with a one-entry
// result buffer, and a flag save/restore stack.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flag_we, CO, OVF, Z, N  latch {N,Z,CO,OVF} into flags
//   cond_valid, cond,       condition request (valid/ready)
//   cond_ready
//   result_valid,           evaluated condition (valid/ready)
//   result_ready, cond_result
//   push, pop               save / restore flags
//   flags                   registered {N,Z,C,V}
//   stack_full, stack_empty, stack_err   stack status (err sticky)
// Build option: define FLAG_FWD_EN to evaluate a request that coincides with
// flag_we against the incoming ALU flags instead of the registered ones.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_we,
  input  logic       CO,
  input  logic       OVF,
  input  logic       Z,
  input  logic       N,
  input  logic       cond_valid,
  input  logic [3:0] cond,
  output logic       cond_ready,
  output logic       result_valid,
  input  logic       result_ready,
  output logic       cond_result,
  input  logic       push,
  input  logic       pop,
  output logic [3:0] flags,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  flags_t flags_q;
  flags_t flags_d;
  logic   result_valid_q;
  logic   result_valid_d;
  logic   cond_result_q;
  logic   cond_result_d;
  flags_t alu_flags;
  flags_t eval_flags;
  flags_t stk_top;
  logic   stk_pop_ok;
  logic   accept;

  assign alu_flags    = {N, Z, CO, OVF};
  assign flags        = flags_q;
  assign result_valid = result_valid_q;
  assign cond_result  = cond_result_q;
  // Buffer can take a new request when empty or being drained this cycle.
  assign cond_ready   = ~result_valid_q | result_ready;
  assign accept       = cond_valid & cond_ready;

  flag_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .din    (flags_q),
    .top    (stk_top),
    .full   (stack_full),
    .empty  (stack_empty),
    .err    (stack_err),
    .pop_ok (stk_pop_ok)
  );

  // Select the flag vector a request is evaluated against.
  always_comb begin
`ifdef FLAG_FWD_EN
    if (flag_we) begin
      eval_flags = alu_flags;
    end else begin
      eval_flags = flags_q;
    end
`else
    eval_flags = flags_q;
`endif
  end

  // Next flags: a fresh ALU write wins over a stack restore.
  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d = alu_flags;
    end else if (stk_pop_ok) begin
      flags_d = stk_top;
    end else begin
      flags_d = flags_q;
    end
  end

  // One-entry result buffer: load on accept, drop on drain, else hold.
  always_comb begin
    result_valid_d = result_valid_q;
    cond_result_d  = cond_result_q;
    if (accept) begin
      result_valid_d = 1'b1;
      cond_result_d  = eval_cond(eval_flags, cond);
    end else if (result_ready) begin
      result_valid_d = 1'b0;
    end else begin
      result_valid_d = result_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q        <= 4'b0000;
      result_valid_q <= 1'b0;
      cond_result_q  <= 1'b0;
    end else begin
      flags_q        <= flags_d;
      result_valid_q <= result_valid_d;
      cond_result_q  <= cond_result_d;
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: a reference model computes the
// expected state each cycle and queues expected results; a separate monitor
// compares each result the DUT hands over against the queue.
module tb_cond_flag_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flag_we, CO, OVF, Z, N;
  logic       cond_valid;
  logic [3:0] cond;
  logic       cond_ready, result_valid, result_ready, cond_result;
  logic       push, pop;
  logic [3:0] flags;
  logic       stack_full, stack_empty, stack_err;

  int total = 0;
  int bad   = 0;

  bit         exp_q[$];
  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  bit         m_err;
  bit         m_rv;

  cond_flag_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .CO(CO), .OVF(OVF), .Z(Z), .N(N),
    .cond_valid(cond_valid), .cond(cond), .cond_ready(cond_ready),
    .result_valid(result_valid), .result_ready(result_ready), .cond_result(cond_result),
    .push(push), .pop(pop), .flags(flags),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Odd codes are the negation of the preceding even code; E/F are always/never.
  function automatic bit ref_cond(input logic [3:0] f, input logic [3:0] cc);
    bit n, z, c, v, b;
    logic [2:0] grp;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    grp = cc[3:1];
    case (grp)
      3'd0: b = z;
      3'd1: b = c;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = c && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return cc[0] ? !b : b;
  endfunction

  // Monitor: every result handed over must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h expected none", cond_result);
      end else begin
        chk("cond_result", cond_result, exp_q.pop_front());
      end
    end
  end

  // One clock cycle: check state, drive inputs, advance the model.
  task automatic cyc(input bit we, input logic [3:0] f, input bit cv, input logic [3:0] cc,
                     input bit rr, input bit pu, input bit po);
    bit rdy, acc;
    logic [3:0] ef, popped;
    chk("flags", flags, m_flags);
    chk("result_valid", result_valid, m_rv);
    chk("stack_full", stack_full, m_stack.size() == DEPTH);
    chk("stack_empty", stack_empty, m_stack.size() == 0);
    chk("stack_err", stack_err, m_err);
    flag_we = we; {N, Z, CO, OVF} = f; cond_valid = cv; cond = cc;
    result_ready = rr; push = pu; pop = po;
    #1;
    rdy = !m_rv || rr;
    chk("cond_ready", cond_ready, rdy);
    acc = cv && rdy;
`ifdef FLAG_FWD_EN
    ef = we ? f : m_flags;
`else
    ef = m_flags;
`endif
    if (acc) exp_q.push_back(ref_cond(ef, cc));
    if (acc) m_rv = 1'b1;
    else if (rr) m_rv = 1'b0;
    if (pu && po) m_err = 1'b1;
    else if (pu) begin
      if (m_stack.size() == DEPTH) m_err = 1'b1;
      else m_stack.push_back(m_flags);
    end else if (po) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else begin
        popped = m_stack.pop_back();
        if (!we) m_flags = popped;
      end
    end
    if (we) m_flags = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_cond_result", cond_result, 1'b0);
    chk("rst_cond_ready", cond_ready, 1'b1);
    chk("rst_stack_empty", stack_empty, 1'b1);
    chk("rst_stack_err", stack_err, 1'b0);
    chk("rst_flags", flags, 4'h0);
    m_flags = 4'h0; m_stack.delete(); m_err = 1'b0; m_rv = 1'b0; exp_q.delete();
    flag_we = 1'b0; {N, Z, CO, OVF} = 4'h0; cond_valid = 1'b0; cond = 4'h0;
    result_ready = 1'b1; push = 1'b0; pop = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_hold_cond_ready", cond_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    flag_we = 1'b0; {N, Z, CO, OVF} = 4'h0; cond_valid = 1'b0; cond = 4'h0;
    result_ready = 1'b1; push = 1'b0; pop = 1'b0;
    #3;
    do_reset();

    // Z=1 written, then EQ evaluated -> 1; flags 0100.
    cyc(1'b1, 4'b0100, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("eq_flags", flags, 4'b0100);
    // N=1, V=0: GE 0, LT 1, NV 0, AL 1.
    cyc(1'b1, 4'b1000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
    // Backpressure: result held for 3 cycles, then back-to-back.
    cyc(1'b0, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
      chk("held_cond_result", cond_result, 1'b1);
    end
    cyc(1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    // Fill the stack with distinct values, overflow once, then pop.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 4'(i + 3), 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    end
    cyc(1'b1, 4'h9, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("overflow_err", stack_err, 1'b1);
    chk("overflow_full", stack_full, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("pop_restore", flags, 4'(DEPTH + 2));
    // flag_we beats restore; stack still pops.
    cyc(1'b1, 4'hC, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    // Same-cycle flag write and EQ request (forwarding dependent).
    cyc(1'b1, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'b0100, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    // Reset with a result pending and two stack entries.
    do_reset();
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
    do_reset();
    // Underflow and simultaneous push/pop errors.
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    do_reset();
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    do_reset();
    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom % 3) == 0, 4'($urandom), ($urandom % 2) == 0, 4'($urandom),
          ($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 5) == 0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
